// File: rtl/guia_pkg.sv
// guia_pkg: shared FSM states, vector count and OR/NOR reference function for the sequencer
package guia_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam int NUM_VECTORS = 8;
  function automatic logic expected_result(input logic a, input logic b, input logic select);
    return select ? ~(a | b) : (a | b);
  endfunction
endpackage

// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: walks 8 operand vectors through an external OR/NOR unit and scores its results
module logic_op_sequencer
  import guia_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       selected_output,
  output logic       a,
  output logic       b,
  output logic       select,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [3:0] err_count
);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_VECTORS - 1);
  state_t state, nxt;
  logic [2:0] idx, idx_n;
  logic [3:0] cnt, cnt_n, err_n;
  logic [7:0] tbl_n;
  logic drv;
  always_comb begin
    nxt = state;
    idx_n = idx;
    cnt_n = cnt;
    tbl_n = table_out;
    err_n = err_count;
    case (state)
      IDLE: if (start) begin
        nxt = DRIVE;
        idx_n = '0;
        cnt_n = '0;
        tbl_n = '0;
        err_n = '0;
      end
      DRIVE: begin
        nxt = (cnt == SETTLE_LAST) ? SAMPLE : DRIVE;
        cnt_n = (cnt == SETTLE_LAST) ? 4'd0 : cnt + 4'd1;
      end
      SAMPLE: begin
        tbl_n[idx] = selected_output;
        err_n = (selected_output != expected_result(a, b, select)) ? err_count + 4'd1 : err_count;
        nxt = (idx == LAST_IDX) ? DONE : DRIVE;
        idx_n = (idx == LAST_IDX) ? idx : idx + 3'd1;
      end
      default: nxt = IDLE;
    endcase
    drv = (nxt == DRIVE) || (nxt == SAMPLE);
  end
  // outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      a <= 1'b0;
      b <= 1'b0;
      select <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      table_out <= '0;
      err_count <= '0;
    end else begin
      state <= nxt;
      idx <= idx_n;
      cnt <= cnt_n;
      a <= drv & idx_n[2];
      b <= drv & idx_n[1];
      select <= drv & idx_n[0];
      busy <= drv;
      done <= (nxt == DONE);
      table_out <= tbl_n;
      err_count <= err_n;
    end
  end
endmodule

// File: tb/tb_logic_op_sequencer.sv
// tb_logic_op_sequencer: randomized fault-mask runs against a behavioural OR/NOR scoring model
module tb_logic_op_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rst, start, so, a, b, sel, busy, done;
  logic [7:0] tbl [2];
  logic [3:0] err [2];
  logic [7:0] mask [2];
  int n_assert = 0;
  int n_fail = 0;

  logic_op_sequencer #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .selected_output(so[0]),
    .a(a[0]), .b(b[0]), .select(sel[0]), .busy(busy[0]), .done(done[0]),
    .table_out(tbl[0]), .err_count(err[0]));
  logic_op_sequencer #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .selected_output(so[1]),
    .a(a[1]), .b(b[1]), .select(sel[1]), .busy(busy[1]), .done(done[1]),
    .table_out(tbl[1]), .err_count(err[1]));

  function automatic logic ideal(input int i);
    int x = (i >> 2) & 1;
    int y = (i >> 1) & 1;
    int s = i & 1;
    int o = x | y;
    return (s != 0) ? (o == 0) : (o != 0);
  endfunction

  function automatic logic [7:0] ideal_table();
    logic [7:0] t = '0;
    for (int i = 0; i < 8; i++) t[i] = ideal(i);
    return t;
  endfunction

  // downstream unit: ideal OR/NOR with per-vector fault flips chosen by mask
  always_comb begin
    so = '0;
    for (int u = 0; u < 2; u++) so[u] = ideal(int'({a[u], b[u], sel[u]})) ^ mask[u][{a[u], b[u], sel[u]}];
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int u, input logic [7:0] m, input bit drive, input bit rel);
    int s = (u == 0) ? 1 : 3;
    int t = 8 * (s + 1);
    mask[u] = m;
    if (drive) start[u] = 1'b1;
    @(posedge clk); #1;
    if (rel) start[u] = 1'b0;
    chk("clr_tbl", tbl[u], 8'h00);
    chk("clr_err", 8'(err[u]), 8'h00);
    for (int n = 0; n < t; n++) begin
      chk("busy", 8'(busy[u]), 8'h01);
      chk("done_early", 8'(done[u]), 8'h00);
      chk("vec", 8'({a[u], b[u], sel[u]}), 8'(n / (s + 1)));
      @(posedge clk); #1;
    end
    chk("done", 8'(done[u]), 8'h01);
    chk("busy_done", 8'(busy[u]), 8'h00);
    chk("ops_done", 8'({a[u], b[u], sel[u]}), 8'h00);
    chk("table", tbl[u], ideal_table() ^ m);
    chk("errs", 8'(err[u]), 8'($countones(m)));
  endtask

  initial begin
    logic [7:0] m;
    int u;
    rst = 2'b11; start = 2'b00; mask[0] = '0; mask[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 8'(busy[k]), 8'h00);
      chk("rst_done", 8'(done[k]), 8'h00);
      chk("rst_ops", 8'({a[k], b[k], sel[k]}), 8'h00);
      chk("rst_tbl", tbl[k], 8'h00);
      chk("rst_err", 8'(err[k]), 8'h00);
    end
    rst = 2'b00;
    @(posedge clk); #1;
    run(0, 8'h00, 1, 1);
    @(posedge clk); #1;
    run(0, 8'h56, 1, 1);
    @(posedge clk); #1;
    run(0, 8'hA9, 1, 1);
    @(posedge clk); #1;
    run(0, 8'hFF, 1, 1);
    @(posedge clk); #1;
    run(1, 8'h00, 1, 1);
    @(posedge clk); #1;
    // idle: result input wiggles, captured results must hold
    mask[0] = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_tbl", tbl[0], ideal_table() ^ 8'hFF);
    chk("idle_err", 8'(err[0]), 8'h08);
    // start held high: no restart while busy, next run after the idle cycle
    run(0, 8'h12, 1, 0);
    @(posedge clk); #1;
    chk("hold_idle_busy", 8'(busy[0]), 8'h00);
    chk("hold_idle_tbl", tbl[0], ideal_table() ^ 8'h12);
    run(0, 8'h81, 0, 1);
    @(posedge clk); #1;
    // reset during vector 4, together with start
    mask[0] = 8'h00;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_vec", 8'({a[0], b[0], sel[0]}), 8'h04);
    rst[0] = 1'b1; start[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0; start[0] = 1'b0;
    chk("abort_busy", 8'(busy[0]), 8'h00);
    chk("abort_ops", 8'({a[0], b[0], sel[0]}), 8'h00);
    chk("abort_tbl", tbl[0], 8'h00);
    chk("abort_err", 8'(err[0]), 8'h00);
    for (int n = 0; n < 20; n++) begin
      chk("abort_no_done", 8'(done[0]), 8'h00);
      @(posedge clk); #1;
    end
    run(0, 8'h00, 1, 1);
    @(posedge clk); #1;
    for (int r = 0; r < 6; r++) begin
      u = int'($urandom_range(1, 0));
      m = 8'($urandom);
      run(u, m, 1, 1);
      @(posedge clk); #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
